// File: rtl/paralelo_a_serial_param.sv
// Parametrised parallel-to-serial lane stage: idle-symbol link training, then valid/ready words
// shifted out one bit per clk32f cycle. Optional underrun counter via `PTOS_IDLE_CNT_EN.
module paralelo_a_serial_param #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] IDLE_SYMBOL = WIDTH'(8'hBC),
  parameter int               TRAIN_WORDS = 4,
  parameter bit               MSB_FIRST   = 1'b1
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             frame_start,
  output logic             link_active
`ifdef PTOS_IDLE_CNT_EN
  ,
  output logic [15:0]      idle_cnt
`endif
);

  localparam int CW  = $clog2(WIDTH);
  localparam int TCW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
  localparam logic [CW-1:0]  LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [TCW-1:0] LAST_TRAIN = TCW'(TRAIN_WORDS - 1);

  typedef enum logic {
    TRAIN,
    ACTIVE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [TCW-1:0]   train_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;
  logic             boundary;
  logic             take;

  assign boundary  = (cnt == LAST_BIT);
  assign take      = in_valid && in_ready;
  assign next_word = take ? in : IDLE_SYMBOL;

  always_ff @(posedge clk32f) begin
    if (reset) begin
      state <= TRAIN;
    end else begin
      state <= state_next;
    end
  end

  // Training ends on the load edge that starts the last idle training frame.
  always_comb begin
    state_next = state;
    if (state == TRAIN && boundary && train_cnt == LAST_TRAIN) begin
      state_next = ACTIVE;
    end
  end

  always_comb begin
    in_ready = !reset && (state == ACTIVE) && boundary;
  end

  always_ff @(posedge clk32f) begin
    if (reset) begin
      train_cnt   <= '0;
      link_active <= 1'b0;
    end else begin
      if (state == TRAIN && boundary && train_cnt != LAST_TRAIN) begin
        train_cnt <= train_cnt + 1'b1;
      end
      if (state_next == ACTIVE) begin
        link_active <= 1'b1;
      end
    end
  end

  // The first bit goes straight to out on the load edge, so the shift register keeps the
  // remaining bits pre-shifted and always presents the next bit at its output end.
  always_ff @(posedge clk32f) begin
    if (reset) begin
      cnt         <= LAST_BIT;
      shift_reg   <= '0;
      out         <= 1'b0;
      frame_start <= 1'b0;
    end else if (boundary) begin
      cnt         <= '0;
      frame_start <= 1'b1;
      if (MSB_FIRST) begin
        out       <= next_word[WIDTH-1];
        shift_reg <= {next_word[WIDTH-2:0], 1'b0};
      end else begin
        out       <= next_word[0];
        shift_reg <= {1'b0, next_word[WIDTH-1:1]};
      end
    end else begin
      cnt         <= cnt + 1'b1;
      frame_start <= 1'b0;
      if (MSB_FIRST) begin
        out       <= shift_reg[WIDTH-1];
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      end else begin
        out       <= shift_reg[0];
        shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
      end
    end
  end

`ifdef PTOS_IDLE_CNT_EN
  // Only underrun idles after training count; saturates rather than wrapping.
  always_ff @(posedge clk32f) begin
    if (reset) begin
      idle_cnt <= 16'h0000;
    end else if (boundary && state == ACTIVE && !take && idle_cnt != 16'hFFFF) begin
      idle_cnt <= idle_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_paralelo_a_serial_param.sv
// Self-checking bench: an 8-bit MSB-first instance and a 10-bit LSB-first instance, each checked
// cycle by cycle against a queue-of-bits reference model. Optional `PTOS_IDLE_CNT_EN port is checked too.
module tb_paralelo_a_serial_param;

  logic clk32f = 1'b0;
  always #5 clk32f = ~clk32f;

  logic       reset_a = 1'b1;
  logic       valid_a = 1'b0;
  logic [7:0] in_a    = '0;
  logic       ready_a, out_a, fs_a, link_a;
  logic       reset_b = 1'b1;
  logic       valid_b = 1'b0;
  logic [9:0] in_b    = '0;
  logic       ready_b, out_b, fs_b, link_b;
`ifdef PTOS_IDLE_CNT_EN
  logic [15:0] idle_a, idle_b;
`endif

  paralelo_a_serial_param dut_a (
    .clk32f(clk32f), .reset(reset_a), .in(in_a), .in_valid(valid_a), .in_ready(ready_a),
    .out(out_a), .frame_start(fs_a), .link_active(link_a)
`ifdef PTOS_IDLE_CNT_EN
    , .idle_cnt(idle_a)
`endif
  );

  paralelo_a_serial_param #(
    .WIDTH(10), .IDLE_SYMBOL(10'h17C), .TRAIN_WORDS(4), .MSB_FIRST(1'b0)
  ) dut_b (
    .clk32f(clk32f), .reset(reset_b), .in(in_b), .in_valid(valid_b), .in_ready(ready_b),
    .out(out_b), .frame_start(fs_b), .link_active(link_b)
`ifdef PTOS_IDLE_CNT_EN
    , .idle_cnt(idle_b)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  bit          sel = 1'b0;
  int          m_w = 8;
  bit          m_msb = 1'b1;
  logic [15:0] m_idle = 16'h00BC;
  int          m_train = 4;

  bit          exp_q[$];
  int          frames_loaded = 0;
  bit          exp_out = 1'b0;
  bit          exp_fs = 1'b0;
  int          exp_idle = 0;
  logic [15:0] src_q[$];
  int          edges = 0;
  bit          seen_ready = 1'b0;

  logic obs_ready, obs_out, obs_fs, obs_link;
  assign obs_ready = sel ? ready_b : ready_a;
  assign obs_out   = sel ? out_b   : out_a;
  assign obs_fs    = sel ? fs_b    : fs_a;
  assign obs_link  = sel ? link_b  : link_a;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // A boundary is any cycle where every bit of the current frame has already been shown.
  function automatic bit model_ready(input bit rst);
    return !rst && exp_q.size() == 0 && frames_loaded >= m_train;
  endfunction

  task automatic model_edge(input bit rst, input bit vld, input logic [15:0] word, output bit consumed);
    logic [15:0] nw;
    consumed = 1'b0;
    if (rst) begin
      exp_q.delete();
      frames_loaded = 0;
      exp_out = 1'b0;
      exp_fs = 1'b0;
      exp_idle = 0;
      return;
    end
    if (exp_q.size() == 0) begin
      nw = m_idle;
      if (frames_loaded >= m_train) begin
        if (vld) begin
          nw = word;
          consumed = 1'b1;
        end else if (exp_idle < 65535) begin
          exp_idle++;
        end
      end
      for (int i = 0; i < m_w; i++) exp_q.push_back(m_msb ? nw[m_w-1-i] : nw[i]);
      if (frames_loaded < m_train) frames_loaded++;
      exp_fs = 1'b1;
    end else begin
      exp_fs = 1'b0;
    end
    exp_out = exp_q.pop_front();
  endtask

  task automatic applyStimulus(input bit rst, input bit vld);
    logic [15:0] word;
    logic [15:0] mask;
    bit consumed;
    mask = 16'((32'd1 << m_w) - 1);
    word = (src_q.size() != 0) ? src_q[0] : (16'($urandom) & mask);
    if (!sel) begin
      reset_a = rst; valid_a = vld; in_a = word[7:0];
    end else begin
      reset_b = rst; valid_b = vld; in_b = word[9:0];
    end
    @(negedge clk32f);
    #1;
    checkOutput("in_ready", 32'(obs_ready), 32'(model_ready(rst)));
    if (obs_ready && !seen_ready) begin
      seen_ready = 1'b1;
      checkOutput("first_ready_cycle", 32'(edges), 32'(m_w * m_train));
    end
    @(posedge clk32f);
    model_edge(rst, vld, word, consumed);
    if (consumed && src_q.size() != 0) src_q.delete(0);
    if (rst) begin
      edges = 0;
      seen_ready = 1'b0;
    end else begin
      edges++;
    end
    #1;
    checkOutput("out", 32'(obs_out), 32'(exp_out));
    checkOutput("frame_start", 32'(obs_fs), 32'(exp_fs));
    checkOutput("link_active", 32'(obs_link), 32'(frames_loaded >= m_train));
`ifdef PTOS_IDLE_CNT_EN
    checkOutput("idle_cnt", 32'(sel ? idle_b : idle_a), 32'(exp_idle));
`endif
  endtask

  // Upstream holds in_valid until every queued word has been taken, with a cycle budget.
  task automatic drainQueue();
    for (int i = 0; i < 300 && src_q.size() != 0; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("send_timeout", 32'(src_q.size()), 32'd0);
    src_q.delete();
  endtask

  task automatic randomTraffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (src_q.size() == 0) src_q.push_back(16'($urandom) & 16'((32'd1 << m_w) - 1));
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    end
    src_q.delete();
  endtask

  initial begin
    sel = 1'b0;
    m_w = 8; m_msb = 1'b1; m_idle = 16'h00BC; m_train = 4;
    repeat (2) applyStimulus(1'b1, 1'b0);

    src_q.push_back(16'h00A5);
    drainQueue();
    src_q.push_back(16'h0001);
    src_q.push_back(16'h00FF);
    src_q.push_back(16'h003C);
    drainQueue();

    src_q.push_back(16'h0012);
    drainQueue();
    repeat (8) applyStimulus(1'b0, 1'b0);
    src_q.push_back(16'h0034);
    drainQueue();

    src_q.push_back(16'h00F0);
    drainQueue();
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (40) applyStimulus(1'b0, 1'b0);

    randomTraffic(800);

    reset_a = 1'b1;
    valid_a = 1'b0;
    sel = 1'b1;
    m_w = 10; m_msb = 1'b0; m_idle = 16'h017C; m_train = 4;
    repeat (2) applyStimulus(1'b1, 1'b0);
    repeat (40) applyStimulus(1'b0, 1'b0);
    src_q.push_back(16'h0001);
    drainQueue();
    repeat (12) applyStimulus(1'b0, 1'b0);
    randomTraffic(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
